// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the result-entry bundle
// carried between the execute stage and EX/MEM.
package alu_pkg;

   localparam int ALU_XLEN  = 32;
   localparam int ALU_TAG_W = 5;

   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_ADD     = 4'b0010,
      ALU_XOR     = 4'b0011,
      ALU_SUB     = 4'b0110,
      ALU_INVALID = 4'b1111
   } alu_ctrl_e;

   typedef struct packed {
      logic [ALU_XLEN-1:0]  result;
      logic                 zero;
      logic                 illegal;
      logic [ALU_TAG_W-1:0] tag;
   } res_entry_t;

   function automatic logic is_legal(input logic [3:0] code);
      return (code == ALU_AND) || (code == ALU_OR) ||
             (code == ALU_ADD) || (code == ALU_XOR) ||
             (code == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational ALU: code, a, b -> result, zero, illegal.
// Unknown codes produce result 0 with illegal set.
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN
) (
   input  logic [3:0]      code,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (code)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_XOR: result = a ^ b;
         ALU_SUB: result = a - b;
         default: begin
            result  = '0;
            illegal = 1'b1;
         end
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready in/out, one OUT register and one
// skid register so that in_ready can be registered at full throughput.
// Ports: clk, rst_n, flush, in_* (valid/ready/op/operands/tag),
// out_* (valid/ready/result/zero/illegal/tag), op_count.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN  = ALU_XLEN,
   parameter int TAG_W = ALU_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_alu_control,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic             out_zero,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      op_count
);

   logic [XLEN-1:0] core_result;
   logic            core_zero;
   logic            core_illegal;

   alu_core #(.XLEN(XLEN)) u_core (
      .code    (in_alu_control),
      .a       (in_a),
      .b       (in_b),
      .result  (core_result),
      .zero    (core_zero),
      .illegal (core_illegal)
   );

   res_entry_t new_e;
   res_entry_t out_q, out_d;
   res_entry_t skid_q, skid_d;
   logic       out_v_q, out_v_d;
   logic       skid_v_q, skid_v_d;

   logic accept;
   logic drain;

   always_comb begin
      new_e         = '0;
      new_e.result  = core_result;
      new_e.zero    = core_zero;
      new_e.illegal = core_illegal;
      new_e.tag     = in_tag;
   end

   assign accept = in_valid && in_ready && !flush;
   assign drain  = out_v_q && out_ready;

   // Next-state of the two-entry store. Ordering is preserved by always
   // refilling OUT from SKID before taking a new entry into OUT.
   always_comb begin
      out_d    = out_q;
      skid_d   = skid_q;
      out_v_d  = out_v_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         out_v_d  = 1'b0;
         skid_v_d = 1'b0;
      end else if (drain && skid_v_q) begin
         out_d    = skid_q;
         out_v_d  = 1'b1;
         skid_v_d = 1'b0;
         if (accept) begin
            skid_d   = new_e;
            skid_v_d = 1'b1;
         end
      end else if (accept && (!out_v_q || drain)) begin
         out_d   = new_e;
         out_v_d = 1'b1;
      end else if (accept) begin
         skid_d   = new_e;
         skid_v_d = 1'b1;
      end else if (drain) begin
         out_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         out_q    <= out_d;
         skid_q   <= skid_d;
         out_v_q  <= out_v_d;
         skid_v_q <= skid_v_d;
         in_ready <= !skid_v_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (accept && (op_count != 16'hFFFF)) begin
         op_count <= op_count + 16'd1;
      end
   end

   assign out_valid   = out_v_q;
   assign out_result  = out_q.result;
   assign out_zero    = out_q.zero;
   assign out_illegal = out_q.illegal;
   assign out_tag     = out_q.tag;

endmodule
